fetch_target_queue: RTL

//   Decoupling FIFO between branch prediction and instruction fetch. Buffers one predicted

---
 rtl/fetch_target_queue_pkg.sv | 44 ++++
 rtl/ftq_ring_ptr.sv | 37 +++
 rtl/fetch_target_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_target_queue_pkg.sv
// Shared fetch-pipeline types: branch info from the predictor and the FTQ entry layout.
// FTQ_DEPTH may be predefined to override the default queue depth.
`ifndef FTQ_DEPTH
`define FTQ_DEPTH 8
`endif

package fetch_target_queue_pkg;

   localparam int FtqDepth      = `FTQ_DEPTH;
   localparam int FtqFetchWidth = 2;
   localparam int FtqBrIdxW     = (FtqFetchWidth > 1) ? $clog2(FtqFetchWidth) : 1;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_COND = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } BrTypeE;

   typedef struct packed {
      logic                 taken;
      logic [1:0]           lphr;
      BrTypeE               br_type;
      logic [2:0]           ras_ptr;
      logic [FtqBrIdxW-1:0] br_idx;
   } BrInfoSt;

   typedef struct packed {
      logic [31:0]              pc;
      logic [FtqFetchWidth-1:0] slot_valid;
      BrInfoSt                  br_info;
   } FtqEntrySt;

   function automatic FtqEntrySt makeEntry(input logic [31:0] pc,
                                           input logic [FtqFetchWidth-1:0] slotValid,
                                           input BrInfoSt brInfo);
      FtqEntrySt entry;
      entry.pc         = pc;
      entry.slot_valid = slotValid;
      entry.br_info    = brInfo;
      return entry;
   endfunction

endpackage

// File: rtl/ftq_ring_ptr.sv
// Ring pointer with a wrap bit above the index; clear wins over increment.
import fetch_target_queue_pkg::*;

module ftq_ring_ptr #(
   parameter int IDX_W = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inc_i,
   input  logic           clr_i,
   output logic [IDX_W:0] ptr_o
);

   logic [IDX_W:0] ptr_q;
   logic [IDX_W:0] ptr_d;

   // The index rolls into the wrap bit because the depth is a power of two.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: decouples branch prediction from ICache fetch, one group per entry.
// Define FTQ_BYPASS_EN for a zero-latency path from the BPU to fetch when the queue is empty.
import fetch_target_queue_pkg::*;

module fetch_target_queue #(
   parameter int DEPTH       = FtqDepth,
   parameter int FETCH_WIDTH = FtqFetchWidth
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   bpu_valid_i,
   input  logic [31:0]            bpu_pc_i,
   input  logic [FETCH_WIDTH-1:0] bpu_slot_valid_i,
   input  BrInfoSt                bpu_br_info_i,
   output logic                   bpu_ready_o,
   output logic                   fetch_valid_o,
   input  logic                   fetch_ready_i,
   output logic [31:0]            fetch_pc_o,
   output logic [FETCH_WIDTH-1:0] fetch_slot_valid_o,
   output BrInfoSt                fetch_br_info_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int IdxW = $clog2(DEPTH);

   logic [IdxW:0] headPtr;
   logic [IdxW:0] tailPtr;
   FtqEntrySt     entryMem_q [DEPTH];
   FtqEntrySt     enqEntry;
   FtqEntrySt     headEntry;
   FtqEntrySt     outEntry;
   logic          isEmpty;
   logic          isFull;
   logic          enqFire;
   logic          deqFire;
   logic          writeEn;

   assign isEmpty = (headPtr == tailPtr);
   assign isFull  = (headPtr[IdxW-1:0] == tailPtr[IdxW-1:0]) && (headPtr[IdxW] != tailPtr[IdxW]);

   // Ready comes from registered pointers only, so the BPU never sees a path from fetch_ready_i.
   assign bpu_ready_o = ~isFull;
   assign enqFire     = bpu_valid_i & ~isFull & (|bpu_slot_valid_i) & ~flush_i;
   assign deqFire     = ~isEmpty & fetch_ready_i & ~flush_i;
   assign enqEntry    = makeEntry(bpu_pc_i, bpu_slot_valid_i, bpu_br_info_i);
   assign headEntry   = entryMem_q[headPtr[IdxW-1:0]];

`ifdef FTQ_BYPASS_EN
   logic bypassHit;

   // A group arriving at an empty queue is shown immediately and only stored if fetch stalls.
   assign bypassHit     = isEmpty & enqFire;
   assign writeEn       = enqFire & ~(bypassHit & fetch_ready_i);
   assign fetch_valid_o = ~isEmpty | bypassHit;
   assign outEntry      = bypassHit ? enqEntry : headEntry;
`else
   assign writeEn       = enqFire;
   assign fetch_valid_o = ~isEmpty;
   assign outEntry      = headEntry;
`endif

   assign fetch_pc_o         = outEntry.pc;
   assign fetch_slot_valid_o = outEntry.slot_valid;
   assign fetch_br_info_o    = outEntry.br_info;
   assign count_o            = tailPtr - headPtr;

   ftq_ring_ptr #(.IDX_W(IdxW)) uHeadPtr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (deqFire),
      .clr_i (flush_i),
      .ptr_o (headPtr)
   );

   ftq_ring_ptr #(.IDX_W(IdxW)) uTailPtr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (writeEn),
      .clr_i (flush_i),
      .ptr_o (tailPtr)
   );

   // Entries are zeroed only by reset; a flush just rewinds the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entryMem_q[i] <= '0;
         end
      end else if (writeEn) begin
         entryMem_q[tailPtr[IdxW-1:0]] <= enqEntry;
      end
   end

endmodule
